// File: rtl/gpr_pkg.sv
// Shared definitions for the general-purpose register file: default
// geometry, the pair-operation encoding and the pair index helper.
package gpr_pkg;

    localparam int unsigned GPR_WIDTH = 8;
    localparam int unsigned GPR_DEPTH = 4;

    // Decoded pair command; OP_BAD is inc and dec requested together
    typedef enum logic [1:0] {
        OP_NONE = 2'd0,
        OP_INC  = 2'd1,
        OP_DEC  = 2'd2,
        OP_BAD  = 2'd3
    } pair_op_t;

    // Register index of the low byte of pair p (high byte is the next, odd, index)
    function automatic int unsigned pair_lo_index(input int unsigned p);
        return p * 2;
    endfunction

endpackage

// File: rtl/gpr_pair_incdec.sv
// Combinational +/-1 on a concatenated register pair, with zero detect.
module gpr_pair_incdec
    import gpr_pkg::*;
#(
    parameter int unsigned WIDTH = GPR_WIDTH
) (
    input  logic [2*WIDTH-1:0] value,
    input  pair_op_t           op,
    output logic [2*WIDTH-1:0] result_c,
    output logic               zero_c
);

    localparam int unsigned PW = 2 * WIDTH;

    // Full-width add/subtract so the carry/borrow crosses the byte boundary
    always_comb begin
        result_c = value;
        case (op)
            OP_INC:  result_c = value + PW'(1);
            OP_DEC:  result_c = value - PW'(1);
            default: result_c = value;
        endcase
        zero_c = (result_c == '0);
    end

endmodule

// File: rtl/general_purpose_register_file.sv
// General-purpose register file with three tri-state read buses, a load
// port sourced from MainBus and a 16-bit pair increment/decrement unit.
// Optional macro GPR_BYPASS_EN: LHSBus/RHSBus forward the MainBus value
// when they read the register being loaded in the same cycle.
module general_purpose_register_file
    import gpr_pkg::*;
#(
    parameter  int unsigned WIDTH = GPR_WIDTH,
    parameter  int unsigned DEPTH = GPR_DEPTH,
    localparam int unsigned SELW  = $clog2(DEPTH),
    localparam int unsigned PSELW = (SELW > 1) ? SELW - 1 : 1
) (
    input  logic             clk,
    input  logic             reset_n,
    inout  wire  [WIDTH-1:0] MainBus,
    inout  wire  [WIDTH-1:0] LHSBus,
    inout  wire  [WIDTH-1:0] RHSBus,
    input  logic [SELW-1:0]  wr_sel,
    input  logic             load_n,
    input  logic [SELW-1:0]  main_sel,
    input  logic [SELW-1:0]  lhs_sel,
    input  logic [SELW-1:0]  rhs_sel,
    input  logic             a_main_n,
    input  logic             a_lhs_n,
    input  logic             a_rhs_n,
    input  logic [PSELW-1:0] pair_sel,
    input  logic             inc_n,
    input  logic             dec_n,
    output logic             pair_zero,
    output logic             conflict
);

    localparam int unsigned PW = 2 * WIDTH;

    logic [WIDTH-1:0] regs [DEPTH];
    logic [SELW-1:0]  lo_idx;
    logic [SELW-1:0]  hi_idx;
    pair_op_t         op_c;
    logic [PW-1:0]    pair_val;
    logic [PW-1:0]    pair_res;
    logic             pair_res_zero;
    logic             load_ok;
    logic             load_clash;
    logic             op_done;
    logic [WIDTH-1:0] lhs_val;
    logic [WIDTH-1:0] rhs_val;

    // Pair register indices: low byte even, high byte odd
    assign lo_idx = SELW'(pair_lo_index(32'(pair_sel)));
    assign hi_idx = lo_idx | SELW'(1);

    // Decode the active-low inc/dec strobes into a pair command
    always_comb begin
        op_c = OP_NONE;
        case ({inc_n, dec_n})
            2'b01:   op_c = OP_INC;
            2'b10:   op_c = OP_DEC;
            2'b00:   op_c = OP_BAD;
            default: op_c = OP_NONE;
        endcase
    end

    assign pair_val = {regs[hi_idx], regs[lo_idx]};

    gpr_pair_incdec #(
        .WIDTH (WIDTH)
    ) u_incdec (
        .value    (pair_val),
        .op       (op_c),
        .result_c (pair_res),
        .zero_c   (pair_res_zero)
    );

    // A load while this block drives MainBus would capture its own output
    assign load_ok    = !load_n && a_main_n;
    assign load_clash = !load_n && !a_main_n;
    assign op_done    = (op_c == OP_INC) || (op_c == OP_DEC);

    // Register array and status flags; a same-cycle load overrides its byte of the pair result
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            regs      <= '{default: '0};
            pair_zero <= 1'b0;
            conflict  <= 1'b0;
        end else begin
            if (op_done) begin
                regs[lo_idx] <= pair_res[WIDTH-1:0];
                regs[hi_idx] <= pair_res[PW-1:WIDTH];
                pair_zero    <= pair_res_zero;
            end
            if (load_ok) begin
                regs[wr_sel] <= MainBus;
            end
            if (load_clash || (op_c == OP_BAD)) begin
                conflict <= 1'b1;
            end
        end
    end

`ifdef GPR_BYPASS_EN
    assign lhs_val = (!load_n && (lhs_sel == wr_sel)) ? MainBus : regs[lhs_sel];
    assign rhs_val = (!load_n && (rhs_sel == wr_sel)) ? MainBus : regs[rhs_sel];
`else
    assign lhs_val = regs[lhs_sel];
    assign rhs_val = regs[rhs_sel];
`endif

    assign MainBus = a_main_n ? {WIDTH{1'bz}} : regs[main_sel];
    assign LHSBus  = a_lhs_n  ? {WIDTH{1'bz}} : lhs_val;
    assign RHSBus  = a_rhs_n  ? {WIDTH{1'bz}} : rhs_val;

endmodule
